// File: rtl/reg64_arb_pkg.sv
// reg64_arb_pkg: shared state type, defaults and round-robin pick helper for reg64_write_arbiter.
package reg64_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
    localparam int DATA_W_DEF = 64;
    localparam int BURST_MAX_DEF = 8;
    // Searching modulo 8 gives the same order as modulo NUM_REQ because unused request bits are zero.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] w;
        w = ptr;
        for (int i = 7; i >= 0; i--)
            if (req[3'(int'(ptr) + i)]) w = 3'(int'(ptr) + i);
        return w;
    endfunction
endpackage

// File: rtl/rr_pick_comb.sv
// rr_pick_comb: round-robin winner search starting at ptr via rotate, priority-encode and unrotate.
module rr_pick_comb #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx
);
    logic [N-1:0]  rot;
    logic [IW-1:0] enc;
    logic [IW:0]   sum;
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        enc = '0;
        for (int i = N - 1; i >= 0; i--) enc = rot[i] ? IW'(i) : enc;
    end
    assign sum = {1'b0, ptr} + {1'b0, enc};
    assign idx = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
endmodule

// File: rtl/reg64_write_arbiter.sv
// reg64_write_arbiter: round-robin burst arbiter for the reg64 write port.
// Define REG64_ARB_PRIO0_EN to make requester 0 fixed high priority over a rotating 1..NUM_REQ-1.
module reg64_write_arbiter
    import reg64_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      wea,
    output logic [DATA_W-1:0]         datain,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        done
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_t state, state_n;
    logic [IW-1:0] rr_ptr, owner, pick, win, next_ptr;
    logic [LEN_W-1:0] beat_cnt, len_w, len_c;
    logic [NUM_REQ-1:0] pick_req;
    logic any, accept, last, finish, advance;
`ifdef REG64_ARB_PRIO0_EN
    assign pick_req = {req[NUM_REQ-1:1], 1'b0};
    assign win = req[0] ? '0 : pick;
    assign advance = owner != '0;
`else
    assign pick_req = req;
    assign win = pick;
    assign advance = 1'b1;
`endif
    rr_pick_comb #(.N(NUM_REQ)) u_pick (
        .req(pick_req),
        .ptr(rr_ptr),
        .idx(pick)
    );
    assign any = |req;
    assign len_w = req_len[win*LEN_W +: LEN_W];
    assign len_c = len_w == '0 ? LEN_W'(1) : len_w > LEN_W'(BURST_MAX) ? LEN_W'(BURST_MAX) : len_w;
    // The final beat is still written when req drops in the same cycle.
    assign accept = state == ARB_BURST && req_valid[owner] && (req[owner] || beat_cnt == LEN_W'(1));
    assign last = accept && beat_cnt == LEN_W'(1);
    assign finish = state == ARB_BURST && (last || !req[owner]);
    assign next_ptr = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
    always_ff @(posedge clk) state <= reset ? ARB_IDLE : state_n;
    always_comb state_n = state == ARB_IDLE ? (any ? ARB_BURST : ARB_IDLE) : (finish ? ARB_IDLE : ARB_BURST);
    always_comb busy = state == ARB_BURST;
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt      <= '0;
            wea      <= 1'b0;
            datain   <= '0;
            done     <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            wea  <= accept;
            done <= last ? NUM_REQ'(1) << owner : '0;
            if (accept) begin
                datain   <= req_data[owner*DATA_W +: DATA_W];
                beat_cnt <= beat_cnt - 1'b1;
            end
            if (state == ARB_IDLE && any) begin
                owner    <= win;
                beat_cnt <= len_c;
                gnt      <= NUM_REQ'(1) << win;
            end
            if (finish) begin
                gnt <= '0;
                if (advance) rr_ptr <= next_ptr;
            end
        end
    end
endmodule

// File: tb/tb_reg64_write_arbiter.sv
// tb_reg64_write_arbiter: vector table, corner-case sequences and a random run against a reference model.
module tb_reg64_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req_valid = '0;
    logic [3:0] len [4];
    logic [63:0] dat [4];
    logic [15:0] req_len;
    logic [255:0] req_data;
    logic [3:0] gnt, done;
    logic wea, busy;
    logic [63:0] datain;
    logic [63:0] reg64 = '0;
    int checks = 0;
    int errors = 0;
    int nw, nb;
    int m_busy = 0, m_own = 0, m_left = 0, m_ptr = 0;
    logic [3:0] m_gnt = '0, m_done = '0;
    logic m_wea = 1'b0;
    logic [63:0] m_dat = '0;

    typedef struct {
        logic [3:0]  req, len, vld;
        logic [63:0] d;
        logic [3:0]  gnt, done;
        logic        wea, busy;
        logic [63:0] dout;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;
    assign req_len = {len[3], len[2], len[1], len[0]};
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};
    always @(posedge clk) if (wea) reg64 <= datain;

    reg64_write_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_valid(req_valid),
        .req_data(req_data), .gnt(gnt), .wea(wea), .datain(datain), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    task automatic model_step();
        int l;
        m_wea = 1'b0;
        m_done = '0;
        if (reset) begin
            m_busy = 0;
            m_own = 0;
            m_left = 0;
            m_ptr = 0;
            m_gnt = '0;
            m_dat = '0;
        end else if (m_busy == 0) begin
            if (req != '0) begin
`ifdef REG64_ARB_PRIO0_EN
                m_own = req[0] ? 0 : first_from(req & 4'b1110, m_ptr);
`else
                m_own = first_from(req, m_ptr);
`endif
                l = int'(len[m_own]);
                m_left = l == 0 ? 1 : (l > 8 ? 8 : l);
                m_gnt = 4'(1 << m_own);
                m_busy = 1;
            end
        end else begin
            if (req_valid[m_own] && (req[m_own] || m_left == 1)) begin
                m_wea = 1'b1;
                m_dat = dat[m_own];
                m_left--;
                if (m_left == 0) m_done = 4'(1 << m_own);
            end
            if (m_left == 0 || !req[m_own]) begin
                m_busy = 0;
                m_gnt = '0;
`ifdef REG64_ARB_PRIO0_EN
                if (m_own != 0) m_ptr = (m_own + 1) % 4;
`else
                m_ptr = (m_own + 1) % 4;
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("m_gnt", 64'(gnt), 64'(m_gnt));
        chk("m_wea", 64'(wea), 64'(m_wea));
        chk("m_datain", datain, m_dat);
        chk("m_done", 64'(done), 64'(m_done));
        chk("m_busy", 64'(busy), 64'(m_busy != 0));
    endtask

    task automatic set_all(input logic [3:0] l, input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            len[k] = l;
            dat[k] = base + 64'(k);
        end
    endtask

    initial begin
        tbl[0]  = '{4'b0010, 4'd3, 4'b0000, 64'h00, 4'b0010, 4'b0000, 1'b0, 1'b1, 64'h00};
        tbl[1]  = '{4'b0010, 4'd3, 4'b0010, 64'h11, 4'b0010, 4'b0000, 1'b1, 1'b1, 64'h11};
        tbl[2]  = '{4'b0010, 4'd3, 4'b0010, 64'h22, 4'b0010, 4'b0000, 1'b1, 1'b1, 64'h22};
        tbl[3]  = '{4'b0010, 4'd3, 4'b0010, 64'h33, 4'b0000, 4'b0010, 1'b1, 1'b0, 64'h33};
        tbl[4]  = '{4'b0000, 4'd3, 4'b0000, 64'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, 64'h33};
        tbl[5]  = '{4'b0010, 4'd2, 4'b0000, 64'h00, 4'b0010, 4'b0000, 1'b0, 1'b1, 64'h33};
        tbl[6]  = '{4'b0010, 4'd2, 4'b0010, 64'h44, 4'b0010, 4'b0000, 1'b1, 1'b1, 64'h44};
        tbl[7]  = '{4'b1111, 4'd2, 4'b1101, 64'h66, 4'b0010, 4'b0000, 1'b0, 1'b1, 64'h44};
        tbl[8]  = '{4'b1111, 4'd2, 4'b0000, 64'h00, 4'b0010, 4'b0000, 1'b0, 1'b1, 64'h44};
        tbl[9]  = '{4'b0010, 4'd2, 4'b0010, 64'h55, 4'b0000, 4'b0010, 1'b1, 1'b0, 64'h55};
        tbl[10] = '{4'b0000, 4'd2, 4'b0000, 64'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, 64'h55};
        set_all(4'd1, 64'hbad0);
        tick();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_wea", 64'(wea), 64'h0);
        chk("rst_datain", datain, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            req = tbl[i].req;
            req_valid = tbl[i].vld;
            set_all(tbl[i].len, 64'hbad0);
            dat[1] = tbl[i].d;
            tick();
            chk("tbl_gnt", 64'(gnt), 64'(tbl[i].gnt));
            chk("tbl_wea", 64'(wea), 64'(tbl[i].wea));
            chk("tbl_datain", datain, tbl[i].dout);
            chk("tbl_done", 64'(done), 64'(tbl[i].done));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].busy));
            if (i == 4) chk("reg64_single", reg64, 64'h33);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_all(4'd1, 64'ha0);
        req = 4'b1111;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt", 64'(gnt), 64'h1 << (i % 4));
            tick();
            chk("rr_idle_gnt", 64'(gnt), 64'h0);
            chk("rr_done", 64'(done), 64'h1 << (i % 4));
            chk("rr_data", datain, 64'ha0 + 64'(i % 4));
        end
        set_all(4'd4, 64'hc0);
        req = 4'b0100;
        req_valid = 4'b0100;
        nw = 0;
        tick();
        chk("ab_gnt", 64'(gnt), 64'b0100);
        tick();
        nw += int'(wea);
        tick();
        nw += int'(wea);
        req = 4'b0000;
        tick();
        nw += int'(wea);
        chk("ab_gnt_clr", 64'(gnt), 64'h0);
        chk("ab_done", 64'(done), 64'h0);
        chk("ab_writes", 64'(nw), 64'd2);
        set_all(4'd5, 64'hd0);
        req = 4'b1000;
        req_valid = 4'b1000;
        tick();
        chk("mr_gnt", 64'(gnt), 64'b1000);
        tick();
        chk("mr_beat1", 64'(wea), 64'h1);
        reset = 1'b1;
        tick();
        chk("mr_wea", 64'(wea), 64'h0);
        chk("mr_gnt_clr", 64'(gnt), 64'h0);
        chk("mr_datain", datain, 64'h0);
        reset = 1'b0;
        req = 4'b1111;
        req_valid = 4'b0000;
        tick();
        chk("mr_regrant", 64'(gnt), 64'b0001);
        req = 4'b0000;
        tick();
        set_all(4'd0, 64'he0);
        req = 4'b0001;
        req_valid = 4'b0001;
        tick();
        chk("len0_gnt", 64'(gnt), 64'b0001);
        tick();
        chk("len0_wea", 64'(wea), 64'h1);
        chk("len0_done", 64'(done), 64'b0001);
        set_all(4'd15, 64'hf0);
        req = 4'b0010;
        req_valid = 4'b0010;
        tick();
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            nb += int'(wea);
            if (done[1]) break;
        end
        chk("len15_done", 64'(done[1]), 64'h1);
        chk("len15_beats", 64'(nb), 64'd8);
        req = 4'b0000;
        req_valid = 4'b0000;
        tick();
        set_all(4'd1, 64'h70);
        req = 4'b0101;
        req_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef REG64_ARB_PRIO0_EN
            chk("prio_gnt", 64'(gnt), 64'b0001);
`else
            chk("prio_gnt", 64'(gnt), i % 2 == 0 ? 64'b0100 : 64'b0001);
`endif
            tick();
        end
        req = 4'b0000;
        tick();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) begin
                req[k] = (m_busy != 0 && m_own == k) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) != 0);
                req_valid[k] = $urandom_range(0, 3) != 0;
                len[k] = 4'($urandom_range(0, 15));
                dat[k] = {$urandom, $urandom};
            end
            reset = $urandom_range(0, 99) == 0;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg64_write_arbiter.md
# reg64_write_arbiter

Round-robin arbiter and burst sequencer that shares the single write port (`wea`/`datain`) of a `reg64` vector register among several requesters: memory-load unit, ALU writeback and so on. A requester wins the port for a burst of 1..BURST_MAX beats and streams data through it. The arbiter registers the selected beat onto the register's write port and releases the grant when the burst completes or is abandoned.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_W`, default 64: data width; matches `reg64`.
- `BURST_MAX`, default 8: maximum beats per grant.
- `LEN_W`, default `$clog2(BURST_MAX+1)`: width of each burst-length field.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request; held high for the whole burst.
- `req_len`  in  NUM_REQ*LEN_W  per-requester burst length; sampled at grant.
- `req_valid`  in  NUM_REQ  per-requester beat valid; honoured only for the granted requester.
- `req_data`  in  NUM_REQ*DATA_W  per-requester beat data.
- `gnt`  out  NUM_REQ  one-hot grant; registered.
- `wea`  out  1  write enable to `reg64`; registered.
- `datain`  out  DATA_W  write data to `reg64`; registered.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  NUM_REQ  one-cycle pulse on the owner's bit when its burst completes normally.

## Operation
- States: IDLE and BURST.
- **IDLE**
  - If any `req` bit is high, the winner is the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Latch the winner index and `beat_cnt = req_len[winner]`; a length of 0 is treated as 1, a length above BURST_MAX is clamped to BURST_MAX.
  - Set `gnt[winner]` and go to BURST.
- **BURST**, each cycle:
  - If the owner's `req_valid` is high: register `wea=1` and `datain=req_data[owner]`, then decrement `beat_cnt`.
  - Otherwise register `wea=0`; `datain` holds its last value.
  - Last beat accepted (`beat_cnt==1` with valid): clear `gnt`, pulse `done[owner]`, set `rr_ptr = owner+1` mod NUM_REQ, go to IDLE.
  - Owner drops `req` before the last beat: abort. Clear `gnt`, emit no `done`, advance `rr_ptr` as above, go to IDLE. A beat presented in the same cycle is not written.
- `req_valid` and `req_data` from requesters that do not hold the grant are ignored.
- A requester that deasserts `req` while IDLE loses nothing: no state is kept per requester.
- `busy` equals (state == BURST).

## Timing
- **Reset values:** `gnt=0`, `wea=0`, `datain=0`, `busy=0`, `done=0`, `rr_ptr=0`, state IDLE. A reset mid-burst drops `wea` and `gnt` at that edge; the pending beat is not written.
- **Grant latency:** `req` sampled high in IDLE at edge N gives `gnt` high after edge N.
- **First beat:** can be presented in the cycle after the grant edge.
- **Write latency:** a beat valid at edge M appears as `wea=1` after edge M, and `reg64` captures it at edge M+1.
- **Between bursts:** there is always exactly one IDLE cycle. Peak throughput is BURST_MAX beats per BURST_MAX+1 cycles.
- **Simultaneous events:** if the last beat and `req` deassertion occur in the same cycle, it counts as normal completion (`done` pulses). New requests arriving during BURST wait for IDLE.
- **Fairness:** each requester waits at most (NUM_REQ-1) bursts.

## Configuration
- Macro `REG64_ARB_PRIO0_EN`.
  - Defined: requester 0 is fixed high priority and wins whenever `req[0]` is high in IDLE. `rr_ptr` is not advanced after requester-0 bursts. Requesters 1..NUM_REQ-1 rotate among themselves.
  - Undefined: pure round-robin over all requesters as described above.

## Structure
- Shared package `reg64_arb_pkg`:
  - state enum `arb_state_t` {ARB_IDLE, ARB_BURST};
  - `DATA_W_DEF=64`, `BURST_MAX_DEF=8`;
  - function `rr_pick(req, ptr)` returning the winner index.
- One natural sub-module, `rr_pick_comb`: combinational rotate, priority-encode and unrotate. The FSM, counter and output registers stay in the top block.

## Test plan
- Single requester: `req[1]=1`, `req_len=3`, valid on 3 consecutive cycles with data 0x11, 0x22, 0x33. Expect `gnt=4'b0010` one cycle after `req`; `wea` high for 3 cycles carrying 0x11, 0x22, 0x33; `done[1]` pulse; `reg64` output 0x33.
- Round-robin: all four `req` held, `len=1` each. Expect grants in order 0,1,2,3,0, each followed by one IDLE cycle.
- Valid gaps: owner with `len=2`, valid pattern 1,0,0,1. Expect `wea` pattern 1,0,0,1 and the grant held throughout.
- Abort: owner with `len=4` drops `req` after 2 beats. Expect `gnt=0` next edge, no `done`, and exactly 2 writes.
- Reset mid-burst: `reset` asserted at beat 2 of 5. Expect `wea=0`, `gnt=0`, `datain=0` after the edge, and the next grant to start from requester 0.
- Boundaries: `req_len=0` gives 1 beat; `req_len=15` gives BURST_MAX (8) beats. Under `REG64_ARB_PRIO0_EN`, `req[0]` and `req[2]` held gives requester 0 winning every arbitration.
